// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bridging execute to a request/grant/response data bus.
// One access in flight; alignment check, lane steering, load extension, watchdog.
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  is_load,
  input  logic [2:0]  is_store,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic [1:0]  err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                       r_state, w_nxt;
  logic [1:0]                   r_boff;
  logic [2:0]                   r_ld;
  logic [CNT_W-1:0]             r_cnt;
  logic [31:0]                  r_rdata;
  logic [1:0]                   r_err;
  logic                         r_ovld;
  logic                         r_mem_we;
  logic [31:0]                  r_mem_addr;
  logic [NUM_LANES-1:0][7:0]    r_mem_wdata;
  logic [NUM_LANES-1:0]         r_mem_wmask;

  logic                         w_acc, w_ld_none, w_st_none, w_ld_ok, w_st_ok;
  logic                         w_is_st, w_mis, w_go, w_to, w_done, w_busy;
  logic [1:0]                   w_size, w_dec_err;
  logic [NUM_LANES-1:0][7:0]    w_sdata;
  logic [NUM_LANES-1:0]         w_smask;
  logic [NUM_LANES-1:0][7:0]    w_rb;
  logic [7:0]                   w_lbyte;
  logic [15:0]                  w_lhalf;
  logic [31:0]                  w_ldata;

  assign w_acc     = in_valid & (r_state == S_IDLE);
  assign w_ld_none = (is_load == 3'b111);
  assign w_st_none = (is_store == 3'b111);
  assign w_ld_ok   = is_load inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_st_ok   = is_store inside {3'b000, 3'b001, 3'b010};
  assign w_is_st   = w_ld_none & ~w_st_none;
  // size code: 0 byte, 1 half, 2 word (low bits of either opcode)
  assign w_size    = w_st_none ? is_load[1:0] : is_store[1:0];
  assign w_mis     = ((w_size == 2'd1) & addr[0]) | ((w_size == 2'd2) & (addr[1:0] != 2'b00));

  always_comb begin
    w_dec_err = 2'b00;
    w_go      = 1'b0;
    if (!w_ld_none && !w_st_none)          w_dec_err = 2'b11;
    else if (w_ld_none && w_st_none)       w_dec_err = 2'b00;
    else if (!(w_ld_none ? w_st_ok : w_ld_ok)) w_dec_err = 2'b11;
    else if (w_mis)                        w_dec_err = 2'b01;
    else                                   w_go      = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    localparam int         HO = (i % 2) * 8;
    assign w_smask[i] = (w_size == 2'd2) | ((w_size == 2'd1) & (addr[1] == LI[1])) |
                        ((w_size == 2'd0) & (addr[1:0] == LI));
    assign w_sdata[i] = (w_size == 2'd0) ? wdata[7:0] :
                        (w_size == 2'd1) ? wdata[HO +: 8] : wdata[i*8 +: 8];
  end

  assign w_rb    = mem_rdata;
  assign w_lbyte = w_rb[r_boff];
  assign w_lhalf = r_boff[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (r_ld)
      3'b000:  w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
      3'b100:  w_ldata = {24'd0, w_lbyte};
      3'b001:  w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
      3'b101:  w_ldata = {16'd0, w_lhalf};
      default: w_ldata = mem_rdata;
    endcase
  end

  assign w_busy = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_to   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_done = (r_state == S_WAIT) & mem_rvalid;

  // a grant arriving with the watchdog expiring is not completion, so timeout wins in REQ
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_nxt = w_go ? S_REQ : S_RESP;
      S_REQ:  if (w_to) w_nxt = S_RESP; else if (mem_gnt) w_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid || w_to) w_nxt = S_RESP;
      S_RESP: if (r_ovld && out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_boff      <= 2'b00;
      r_ld        <= 3'b111;
      r_cnt       <= '0;
      r_rdata     <= 32'd0;
      r_err       <= 2'b00;
      r_ovld      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else begin
      r_state <= w_nxt;
      // result register stage: out_valid follows RESP entry by one cycle
      r_ovld  <= (r_state == S_RESP) & ~(r_ovld & out_ready);
      if (w_acc) begin
        r_boff      <= addr[1:0];
        r_ld        <= is_load;
        r_cnt       <= '0;
        r_rdata     <= 32'd0;
        r_err       <= w_dec_err;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_we    <= w_go & w_is_st;
        r_mem_wdata <= (w_go & w_is_st) ? w_sdata : '0;
        r_mem_wmask <= (w_go & w_is_st) ? w_smask : '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_err <= 2'b00;
        if (!r_mem_we) r_rdata <= w_ldata;
      end else if (w_busy && w_to) begin
        r_err <= 2'b10;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign out_valid = r_ovld;
  assign rdata     = r_rdata;
  assign err       = r_err;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed cases plus random accesses vs. a byte-level model.
module tb_lsu_bus_ctrl;
  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] addr, wdata;
  logic [2:0]  is_load, is_store;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready;
  logic [31:0] rdata;
  logic [1:0]  err;

  int n_chk = 0;
  int n_err = 0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
    .is_load(is_load), .is_store(is_store), .wdata(wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: operand size in bytes, offset in word, replicate / shift / extend.
  function automatic void model(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic [1:0] e, output logic [31:0] rd, output bit bus,
                                output bit we, output logic [31:0] bwd, output logic [3:0] bm);
    int nb, off;
    bit sgn, ldn, stn;
    logic [31:0] v;
    ldn = (ld == 3'b111); stn = (st == 3'b111);
    e = 2'b00; rd = 32'd0; bus = 0; we = 0; bwd = 32'd0; bm = 4'd0;
    nb = 0; sgn = 0; off = int'(a[1:0]);
    if (!ldn && !stn) e = 2'b11;
    else if (!(ldn && stn)) begin
      if (!ldn) begin
        case (ld)
          3'b000: begin nb = 1; sgn = 1; end
          3'b001: begin nb = 2; sgn = 1; end
          3'b010: nb = 4;
          3'b100: nb = 1;
          3'b101: nb = 2;
          default: nb = 0;
        endcase
      end else begin
        case (st)
          3'b000: nb = 1;
          3'b001: nb = 2;
          3'b010: nb = 4;
          default: nb = 0;
        endcase
      end
      if (nb == 0) e = 2'b11;
      else if (off % nb != 0) e = 2'b01;
      else begin
        bus = 1; we = ldn;
        if (we) begin
          bm = 4'(((1 << nb) - 1) << off);
          for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end else begin
          v = word >> (8 * off);
          if (nb < 4) begin
            v = v & ((32'h1 << (8 * nb)) - 32'h1);
            if (sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
          end
          rd = v;
        end
      end
    end
  endfunction

  task automatic txn(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] word,
                     input int gdly, input int rdly, input int ordly, input bit junk);
    logic [1:0]  e;
    logic [31:0] rd, bwd;
    logic [3:0]  bm;
    bit bus, we, tmo;
    int w, cyc, reqc, gcyc, elat, ereq;
    model(ld, st, a, wd, word, e, rd, bus, we, bwd, bm);
    tmo = bus && (gdly >= TO);
    if (tmo) begin e = 2'b10; rd = 32'd0; end
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1; is_load = ld; is_store = st; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; is_load = 3'b111; is_store = 3'b111; addr = $urandom; wdata = $urandom;
    cyc = 1; reqc = 0; gcyc = -1;
    while (!out_valid && cyc < 600) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk("mem_addr", mem_addr, {a[31:2], 2'b00});
          chk("mem_we", 32'(mem_we), 32'(we));
          chk("mem_wmask", 32'(mem_wmask), 32'(bm));
          if (we) chk("mem_wdata", mem_wdata, bwd);
        end
        if (gcyc < 0 && reqc == gdly + 1) begin
          mem_gnt = 1'b1; gcyc = cyc;
          if (junk) begin mem_rvalid = 1'b1; mem_rdata = ~word; end
        end
      end else if (gcyc >= 0 && cyc == gcyc + rdly) begin
        mem_rvalid = 1'b1; mem_rdata = word;
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    elat = !bus ? 2 : tmo ? TO + 2 : gdly + rdly + 3;
    ereq = !bus ? 0 : tmo ? TO : gdly + 1;
    chk("latency", 32'(cyc), 32'(elat));
    chk("req_cycles", 32'(reqc), 32'(ereq));
    chk("mem_req_resp", 32'(mem_req), 32'd0);
    for (int k = 0; k < ordly; k++) begin
      chk("hold_rdata", rdata, rd);
      chk("hold_err", 32'(err), 32'(e));
      chk("hold_ovld", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("rdata", rdata, rd);
    chk("err", 32'(err), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovld_after", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic rst_mid(input bit in_wait);
    in_valid = 1'b1; is_load = 3'b010; is_store = 3'b111; addr = 32'h8000_0010;
    @(negedge clk);
    in_valid = 1'b0; is_load = 3'b111;
    chk("rst_req_up", 32'(mem_req), 32'd1);
    if (in_wait) begin
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("rst_in_wait", 32'(mem_req), 32'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'd0);
    chk("rst_async_ovld", 32'(out_valid), 32'd0);
    chk("rst_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_rv_ovld", 32'(out_valid), 32'd0);
      chk("late_rv_ready", 32'(in_ready), 32'd1);
      chk("late_rv_req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [2:0] ld, st;
    logic [31:0] a;
    int r;
    rst = 1'b1; in_valid = 1'b0; addr = 32'd0; is_load = 3'b111; is_store = 3'b111;
    wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(3'b010, 3'b111, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 1, 0, 0);
    chk("lw_value", rdata, 32'hDEAD_BEEF);
    txn(3'b000, 3'b111, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 1, 0, 1);
    txn(3'b100, 3'b111, 32'h8000_0003, 32'd0, 32'h80FF_1234, 1, 2, 0, 0);
    txn(3'b001, 3'b111, 32'h8000_0002, 32'd0, 32'h80FF_1234, 0, 1, 1, 1);
    txn(3'b101, 3'b111, 32'h8000_0002, 32'd0, 32'h80FF_1234, 2, 1, 0, 0);
    txn(3'b111, 3'b000, 32'h8000_0002, 32'h0000_00AB, 32'd0, 3, 1, 0, 0);
    txn(3'b111, 3'b001, 32'h8000_0001, 32'h0000_BEEF, 32'd0, 0, 1, 0, 0);
    txn(3'b010, 3'b010, 32'h8000_0000, 32'h1, 32'd0, 0, 1, 0, 0);
    txn(3'b111, 3'b111, 32'h8000_0000, 32'h1, 32'd0, 0, 1, 0, 0);
    txn(3'b010, 3'b111, 32'h8000_0008, 32'd0, 32'hCAFE_F00D, 100000, 1, 0, 0);
    txn(3'b001, 3'b111, 32'h8000_0006, 32'd0, 32'h8123_4567, 1, 1, 5, 0);
    rst_mid(1'b0);
    rst_mid(1'b1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      ld = 3'b111; st = 3'b111;
      if (r < 5) ld = 3'($urandom_range(0, 6));
      else if (r < 8) st = 3'($urandom_range(0, 6));
      else if (r == 9) begin ld = 3'($urandom_range(0, 6)); st = 3'($urandom_range(0, 6)); end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      txn(ld, st, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
